// File: rtl/frq_cntr_pkg.sv
// Shared types and defaults for the multi-channel frequency counter.
// Input sampling depth is selected by MULTI_FRQ_CNTR_SYNC_EN (see frq_ch).
package frq_cntr_pkg;

  localparam int DEF_N_CH   = 4;
  localparam int DEF_CNT_W  = 32;
  localparam int DEF_GATE_W = 32;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'b00,
    EDGE_FALL = 2'b01,
    EDGE_BOTH = 2'b10,
    EDGE_RSVD = 2'b11
  } edge_mode_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_COUNT = 1'b1
  } state_e;

  // Reserved encoding falls through to rising-edge detection.
  function automatic logic edge_hit(input logic cur, input logic prv, input edge_mode_e mode);
    logic hit;
    case (mode)
      EDGE_FALL: hit = prv & ~cur;
      EDGE_BOTH: hit = cur ^ prv;
      default:   hit = cur & ~prv;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/frq_ch.sv
// One measurement channel: input sampling, edge detect, saturating counter, result latch.
// MULTI_FRQ_CNTR_SYNC_EN inserts a 2-flop synchroniser ahead of the sample register.
module frq_ch
  import frq_cntr_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig,
  input  logic             count_en,
  input  logic             window_end,
  input  edge_mode_e       mode,
  output logic [CNT_W-1:0] freq,
  output logic             ovf
);

  logic             samp_reg;
  logic             prev_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W-1:0] cnt_result;
  logic             ovf_win_reg;
  logic             ovf_win_next;
  logic [CNT_W-1:0] freq_reg;
  logic             ovf_reg;
  logic             hit;
  logic             at_max;

`ifdef MULTI_FRQ_CNTR_SYNC_EN
  logic [1:0] sync_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= '0;
      samp_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[0], sig};
      samp_reg <= sync_reg[1];
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) samp_reg <= 1'b0;
    else        samp_reg <= sig;
  end
`endif

  // Tracks the sample continuously so entering COUNT never sees a stale edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_reg <= 1'b0;
    else        prev_reg <= samp_reg;
  end

  always_comb begin
    hit          = edge_hit(samp_reg, prev_reg, mode);
    at_max       = &cnt_reg;
    cnt_next     = (hit && !at_max) ? cnt_reg + CNT_W'(1) : cnt_reg;
    ovf_win_next = ovf_win_reg | (hit & at_max);
    cnt_result   = (mode == EDGE_BOTH) ? (cnt_next >> 1) : cnt_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg     <= '0;
      ovf_win_reg <= 1'b0;
      freq_reg    <= '0;
      ovf_reg     <= 1'b0;
    end else if (!count_en) begin
      cnt_reg     <= '0;
      ovf_win_reg <= 1'b0;
    end else if (window_end) begin
      cnt_reg     <= '0;
      ovf_win_reg <= 1'b0;
      freq_reg    <= cnt_result;
      ovf_reg     <= ovf_win_next;
    end else begin
      cnt_reg     <= cnt_next;
      ovf_win_reg <= ovf_win_next;
    end
  end

  assign freq = freq_reg;
  assign ovf  = ovf_reg;

endmodule

// File: rtl/multi_frq_cntr.sv
// Multi-channel frequency counter: shared gate timer, run/stop FSM and result handshake.
// Build option MULTI_FRQ_CNTR_SYNC_EN adds input synchronisers in every channel.
module multi_frq_cntr
  import frq_cntr_pkg::*;
#(
  parameter int N_CH   = DEF_N_CH,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int GATE_W = DEF_GATE_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CH-1:0]       sig_in,
  input  logic                  enable,
  input  logic [GATE_W-1:0]     gate_cycles,
  input  logic [1:0]            edge_mode,
  input  logic                  rd_ack,
  output logic [N_CH*CNT_W-1:0] freq,
  output logic [N_CH-1:0]       ovf,
  output logic                  valid,
  output logic                  overrun
);

  state_e            state_reg;
  state_e            state_next;
  logic [GATE_W-1:0] timer_reg;
  logic [GATE_W-1:0] gate_last_reg;
  edge_mode_e        mode_reg;
  logic              count_en;
  logic              window_end;
  logic              start_window;
  logic              valid_reg;
  logic              overrun_reg;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (enable)  state_next = ST_COUNT;
      ST_COUNT: if (!enable) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  // Dropping enable inside COUNT suppresses both counting and the terminal cycle.
  assign count_en     = (state_reg == ST_COUNT) && enable;
  assign window_end   = count_en && (timer_reg == gate_last_reg);
  assign start_window = ((state_reg == ST_IDLE) && enable) || window_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      timer_reg <= '0;
    else if (!count_en || window_end) timer_reg <= '0;
    else                             timer_reg <= timer_reg + GATE_W'(1);
  end

  // Window length and edge mode are frozen at every window start; 0 means 1 cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gate_last_reg <= '0;
      mode_reg      <= EDGE_RISE;
    end else if (start_window) begin
      gate_last_reg <= (gate_cycles == '0) ? '0 : gate_cycles - GATE_W'(1);
      mode_reg      <= (edge_mode_e'(edge_mode) == EDGE_RSVD) ? EDGE_RISE : edge_mode_e'(edge_mode);
    end
  end

  // A fresh result beats a coincident acknowledge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg   <= 1'b0;
      overrun_reg <= 1'b0;
    end else if (window_end) begin
      valid_reg   <= 1'b1;
      overrun_reg <= (valid_reg | overrun_reg) & ~rd_ack;
    end else if (rd_ack) begin
      valid_reg   <= 1'b0;
      overrun_reg <= 1'b0;
    end
  end

  assign valid   = valid_reg;
  assign overrun = overrun_reg;

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      frq_ch #(
        .CNT_W(CNT_W)
      ) u_ch (
        .clk       (clk),
        .rst_n     (rst_n),
        .sig       (sig_in[gi]),
        .count_en  (count_en),
        .window_end(window_end),
        .mode      (mode_reg),
        .freq      (freq[gi*CNT_W +: CNT_W]),
        .ovf       (ovf[gi])
      );
    end
  endgenerate

endmodule
